// File: rtl/twi_pkg.sv
// Shared types and bus constants for the TWI target.
// State encoding plus the ACK/NACK and R/W bit meanings on the wire.
package twi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } twi_state_t;

    localparam logic TWI_ACK     = 1'b0;
    localparam logic TWI_NACK    = 1'b1;
    localparam logic TWI_RW_READ = 1'b1;

endpackage

// File: rtl/twi_slave_logic_if.sv
// Bus lines and local byte interface of the TWI target.
// The slave modport is the target's view; master is the bus/local-side view.
interface twi_slave_logic_if;
    logic       iScl;
    logic       iSda;
    logic       oSda;
    logic       iEnable;
    logic       iRxAck;
    logic [7:0] oRxData;
    logic       oRxValid;
    logic       oRxFirst;
    logic [7:0] iTxData;
    logic       oTxReq;
    logic       oNackRx;
    logic       oStopSeen;
    logic       oBusy;
    logic       oAddrMatch;

    modport slave (
        input  iScl, iSda, iEnable, iRxAck, iTxData,
        output oSda, oRxData, oRxValid, oRxFirst, oTxReq, oNackRx,
               oStopSeen, oBusy, oAddrMatch
    );

    modport master (
        output iScl, iSda, iEnable, iRxAck, iTxData,
        input  oSda, oRxData, oRxValid, oRxFirst, oTxReq, oNackRx,
               oStopSeen, oBusy, oAddrMatch
    );
endinterface

// File: rtl/twi_line_filter.sv
// Synchronizer + glitch filter + edge pulses for one bus line.
// Latency SYNC_STAGES+FILTER_LEN clocks to the filtered level; no backpressure.
module twi_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   filt;
    logic                   filt_d;
    logic                   samp;

    assign samp = sync[SYNC_STAGES-1];

    // Idle bus level is high, so everything resets to 1 and no edge fires on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '1;
            cnt    <= '0;
            filt   <= 1'b1;
            filt_d <= 1'b1;
        end else begin
            sync   <= (sync << 1) | SYNC_STAGES'(din);
            filt_d <= filt;
            if (samp != filt) begin
                if (cnt == LAST) begin
                    filt <= samp;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign level = filt;
    assign rise  = filt & ~filt_d;
    assign fall  = ~filt & filt_d;
endmodule

// File: rtl/twi_slave_logic.sv
// 7-bit-address TWI target: filtered SCL/SDA, open-drain SDA drive, byte-wide local side.
// Reacts SYNC_STAGES+FILTER_LEN+1 clocks after a bus edge; no clock stretching, local side must keep up.
module twi_slave_logic
    import twi_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3
) (
    input logic              iPlbClk,
    input logic              iPlbResetN,
    twi_slave_logic_if.slave bus
);
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    twi_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
        .clk(iPlbClk), .rst_n(iPlbResetN), .din(bus.iScl),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    twi_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
        .clk(iPlbClk), .rst_n(iPlbResetN), .din(bus.iSda),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    twi_state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] tx_shift;
    logic       rw;
    logic       armed;
    logic       byte_done;
    logic       sda_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q, rx_first_q, tx_req_q, nack_q, stop_q, busy_q, match_q;

    logic start_det, stop_det, addr_hit;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    // shift still holds the seven address bits when the R/W bit arrives; general call never matches.
    assign addr_hit  = (shift[6:0] == SLAVE_ADDR) && (SLAVE_ADDR != 7'd0);

    always_ff @(posedge iPlbClk or negedge iPlbResetN) begin
        if (!iPlbResetN) begin
            state      <= IDLE;
            bit_cnt    <= 3'd7;
            shift      <= '0;
            tx_shift   <= '0;
            rw         <= 1'b0;
            armed      <= 1'b0;
            byte_done  <= 1'b0;
            sda_q      <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            tx_req_q   <= 1'b0;
            nack_q     <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            tx_req_q   <= 1'b0;
            nack_q     <= 1'b0;
            stop_q     <= 1'b0;
            if (!bus.iEnable) begin
                state     <= IDLE;
                sda_q     <= 1'b1;
                busy_q    <= 1'b0;
                match_q   <= 1'b0;
                byte_done <= 1'b0;
            end else if (start_det) begin
                state     <= ADDR;
                bit_cnt   <= 3'd7;
                busy_q    <= 1'b1;
                match_q   <= 1'b0;
                sda_q     <= 1'b1;
                armed     <= 1'b0;
                byte_done <= 1'b0;
            end else if (stop_det) begin
                state     <= IDLE;
                sda_q     <= 1'b1;
                busy_q    <= 1'b0;
                stop_q    <= match_q;
                match_q   <= 1'b0;
                byte_done <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise && !byte_done) begin
                            shift <= {shift[6:0], sda_lvl};
                            if (bit_cnt != 3'd0) begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end else if (addr_hit) begin
                                rw        <= sda_lvl;
                                match_q   <= 1'b1;
                                byte_done <= 1'b1;
                            end else begin
                                state <= IGNORE;
                            end
                        end else if (scl_fall && byte_done) begin
                            state     <= ADDR_ACK;
                            sda_q     <= TWI_ACK;
                            byte_done <= 1'b0;
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 3'd7;
                            if (rw == TWI_RW_READ) begin
                                tx_shift <= bus.iTxData;
                                tx_req_q <= 1'b1;
                                sda_q    <= bus.iTxData[7];
                                state    <= RD_DATA;
                            end else begin
                                sda_q <= 1'b1;
                                armed <= 1'b1;
                                state <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise && !byte_done) begin
                            shift <= {shift[6:0], sda_lvl};
                            if (bit_cnt != 3'd0) begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end else begin
                                byte_done  <= 1'b1;
                                rx_data_q  <= {shift[6:0], sda_lvl};
                                rx_valid_q <= 1'b1;
                                rx_first_q <= armed;
                                armed      <= 1'b0;
                            end
                        end else if (scl_fall && byte_done) begin
                            sda_q     <= ~bus.iRxAck;
                            byte_done <= 1'b0;
                            state     <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_q   <= 1'b1;
                            bit_cnt <= 3'd7;
                            state   <= WR_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd0) begin
                                sda_q     <= 1'b1;
                                byte_done <= 1'b0;
                                state     <= RD_ACK;
                            end else begin
                                sda_q    <= tx_shift[6];
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                bit_cnt  <= bit_cnt - 3'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        // byte_done here records that the master acknowledged.
                        if (scl_rise && !byte_done) begin
                            if (sda_lvl == TWI_ACK) begin
                                byte_done <= 1'b1;
                            end else begin
                                nack_q <= 1'b1;
                                state  <= IGNORE;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            tx_shift  <= bus.iTxData;
                            tx_req_q  <= 1'b1;
                            sda_q     <= bus.iTxData[7];
                            bit_cnt   <= 3'd7;
                            state     <= RD_DATA;
                        end
                    end
                    IGNORE: sda_q <= 1'b1;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.oSda       = sda_q;
    assign bus.oRxData    = rx_data_q;
    assign bus.oRxValid   = rx_valid_q;
    assign bus.oRxFirst   = rx_first_q;
    assign bus.oTxReq     = tx_req_q;
    assign bus.oNackRx    = nack_q;
    assign bus.oStopSeen  = stop_q;
    assign bus.oBusy      = busy_q;
    assign bus.oAddrMatch = match_q;
endmodule

// File: tb/tb_twi_slave_logic.sv
// Directed bench for twi_slave_logic: bit-banged TWI master on a wired-AND SDA,
// strobe counters, and immediate assertions against hand-computed values.
module tb_twi_slave_logic;
    logic iPlbClk    = 1'b0;
    logic iPlbResetN = 1'b0;
    logic scl_m      = 1'b1;
    logic sda_m      = 1'b1;

    int checks = 0;
    int errors = 0;

    twi_slave_logic_if bus ();
    assign bus.iScl = scl_m;
    assign bus.iSda = sda_m & bus.oSda;

    twi_slave_logic #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
        .iPlbClk   (iPlbClk),
        .iPlbResetN(iPlbResetN),
        .bus       (bus)
    );

    always #5 iPlbClk = ~iPlbClk;

    int         rx_cnt = 0, tx_cnt = 0, nack_cnt = 0, stop_cnt = 0, low_cnt = 0, match_cnt = 0;
    logic [7:0] rx_log    [0:15];
    logic       first_log [0:15];

    always @(negedge iPlbClk) begin
        #1;
        if (iPlbResetN) begin
            if (bus.oRxValid) begin
                rx_log[rx_cnt % 16]    = bus.oRxData;
                first_log[rx_cnt % 16] = bus.oRxFirst;
                rx_cnt++;
            end
            if (bus.oTxReq)     tx_cnt++;
            if (bus.oNackRx)    nack_cnt++;
            if (bus.oStopSeen)  stop_cnt++;
            if (!bus.oSda)      low_cnt++;
            if (bus.oAddrMatch) match_cnt++;
        end
    end

    int s_rx, s_tx, s_nack, s_stop, s_low, s_match;

    task automatic snap();
        s_rx = rx_cnt; s_tx = tx_cnt; s_nack = nack_cnt;
        s_stop = stop_cnt; s_low = low_cnt; s_match = match_cnt;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge iPlbClk);
    endtask

    // One SCL period: 12 clocks low (data set at +4), 12 clocks high, sample at mid-high.
    task automatic send_bit(input logic b, input logic glitch, output logic s);
        tick(4);
        if (glitch) begin
            scl_m = 1'b1;
            tick(1);
            scl_m = 1'b0;
        end
        sda_m = b;
        tick(8);
        scl_m = 1'b1;
        tick(6);
        s = bus.iSda;
        tick(6);
        scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic glitch, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(d[i], glitch && (i == 6), s);
        send_bit(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(input logic ack_bit, input logic [7:0] next_tx, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        bus.iTxData = next_tx;
        send_bit(ack_bit, 1'b0, s);
    endtask

    task automatic do_start();
        sda_m = 1'b0;
        tick(12);
        scl_m = 1'b0;
    endtask

    task automatic do_rstart();
        tick(4);
        sda_m = 1'b1;
        tick(8);
        scl_m = 1'b1;
        tick(12);
        sda_m = 1'b0;
        tick(12);
        scl_m = 1'b0;
    endtask

    task automatic do_stop();
        tick(4);
        sda_m = 1'b0;
        tick(8);
        scl_m = 1'b1;
        tick(12);
        sda_m = 1'b1;
        tick(12);
    endtask

    initial begin
        logic       a;
        logic [7:0] d;
        bus.iEnable = 1'b1;
        bus.iRxAck  = 1'b1;
        bus.iTxData = 8'h00;
        tick(3);

        check("rst_sda", bus.oSda, 1);
        check("rst_rxdata", bus.oRxData, 0);
        check("rst_busy", bus.oBusy, 0);
        check("rst_match", bus.oAddrMatch, 0);
        check("rst_strobes", {bus.oRxValid, bus.oRxFirst, bus.oTxReq, bus.oNackRx, bus.oStopSeen}, 0);
        iPlbResetN = 1'b1;
        tick(20);

        // Write 0x3C
        snap();
        do_start();
        check("wr_busy", bus.oBusy, 1);
        send_byte(8'hA0, 1'b0, a);
        check("wr_addr_ack", a, 0);
        check("wr_match", bus.oAddrMatch, 1);
        send_byte(8'h3C, 1'b0, a);
        check("wr_data_ack", a, 0);
        do_stop();
        check("wr_rx_count", rx_cnt - s_rx, 1);
        check("wr_rx_data", rx_log[s_rx % 16], 8'h3C);
        check("wr_rx_first", first_log[s_rx % 16], 1);
        check("wr_stop_count", stop_cnt - s_stop, 1);
        check("wr_busy_end", bus.oBusy, 0);
        check("wr_match_end", bus.oAddrMatch, 0);

        // Read 0x96 (ACK) then 0x5A (NACK)
        snap();
        bus.iTxData = 8'h96;
        do_start();
        send_byte(8'hA1, 1'b0, a);
        check("rd_addr_ack", a, 0);
        read_byte(1'b0, 8'h5A, d);
        check("rd_byte1", d, 8'h96);
        read_byte(1'b1, 8'h5A, d);
        check("rd_byte2", d, 8'h5A);
        tick(10);
        check("rd_released", bus.oSda, 1);
        do_stop();
        check("rd_txreq_count", tx_cnt - s_tx, 2);
        check("rd_nack_count", nack_cnt - s_nack, 1);
        check("rd_stop_count", stop_cnt - s_stop, 1);
        check("rd_rx_count", rx_cnt - s_rx, 0);

        // Address mismatch
        snap();
        do_start();
        send_byte(8'hA2, 1'b0, a);
        check("mm_addr_ack", a, 1);
        check("mm_busy", bus.oBusy, 1);
        check("mm_match", bus.oAddrMatch, 0);
        send_byte(8'h55, 1'b0, a);
        check("mm_data_ack", a, 1);
        do_stop();
        check("mm_sda_low_cycles", low_cnt - s_low, 0);
        check("mm_match_cycles", match_cnt - s_match, 0);
        check("mm_strobes", (rx_cnt - s_rx) + (tx_cnt - s_tx) + (nack_cnt - s_nack), 0);
        check("mm_stop_count", stop_cnt - s_stop, 0);
        check("mm_busy_end", bus.oBusy, 0);

        // Local side refuses the second byte
        snap();
        do_start();
        send_byte(8'hA0, 1'b0, a);
        check("nk_addr_ack", a, 0);
        send_byte(8'h11, 1'b0, a);
        check("nk_ack1", a, 0);
        bus.iRxAck = 1'b0;
        send_byte(8'h22, 1'b0, a);
        check("nk_ack2", a, 1);
        bus.iRxAck = 1'b1;
        do_stop();
        check("nk_rx_count", rx_cnt - s_rx, 2);
        check("nk_rx0_data", rx_log[s_rx % 16], 8'h11);
        check("nk_rx0_first", first_log[s_rx % 16], 1);
        check("nk_rx1_data", rx_log[(s_rx + 1) % 16], 8'h22);
        check("nk_rx1_first", first_log[(s_rx + 1) % 16], 0);

        // Repeated START: write 0x10, then read one byte
        snap();
        bus.iTxData = 8'hC3;
        do_start();
        send_byte(8'hA0, 1'b0, a);
        check("rs_addr1_ack", a, 0);
        send_byte(8'h10, 1'b0, a);
        check("rs_data_ack", a, 0);
        do_rstart();
        check("rs_match_cleared", bus.oAddrMatch, 0);
        send_byte(8'hA1, 1'b0, a);
        check("rs_addr2_ack", a, 0);
        read_byte(1'b1, 8'hC3, d);
        check("rs_rd_byte", d, 8'hC3);
        do_stop();
        check("rs_rx_count", rx_cnt - s_rx, 1);
        check("rs_rx_data", rx_log[s_rx % 16], 8'h10);
        check("rs_rx_first", first_log[s_rx % 16], 1);
        check("rs_txreq_count", tx_cnt - s_tx, 1);
        check("rs_stop_count", stop_cnt - s_stop, 1);

        // Asynchronous reset while driving SDA low during a read
        bus.iTxData = 8'h00;
        do_start();
        send_byte(8'hA1, 1'b0, a);
        check("ar_addr_ack", a, 0);
        tick(8);
        check("ar_sda_low", bus.oSda, 0);
        iPlbResetN = 1'b0;
        #1;
        check("ar_sda_released", bus.oSda, 1);
        check("ar_busy", bus.oBusy, 0);
        check("ar_match", bus.oAddrMatch, 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(4);
        iPlbResetN = 1'b1;
        tick(20);

        // One-clock SCL glitch inside an address bit
        snap();
        do_start();
        send_byte(8'hA0, 1'b1, a);
        check("gl_addr_ack", a, 0);
        check("gl_match", bus.oAddrMatch, 1);
        do_stop();
        check("gl_stop_count", stop_cnt - s_stop, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/twi_slave_logic.md
Name: twi_slave_logic

Overview:
- 7-bit-address TWI (I2C) target that answers the bus driven by the team's PLB TWI master.
- Samples SCL/SDA on the PLB clock and drives SDA open-drain: oSda=1 releases, oSda=0 pulls low.
- Hands write bytes to, and takes read bytes from, a local byte interface.
- Standard-mode framing: START, 8-bit address+R/W, ACK, data bytes, repeated START, STOP. No clock stretching.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit target address; general call (0x00) is never acknowledged.
SYNC_STAGES, 2, metastability flops per input line.
FILTER_LEN, 3, consecutive equal samples needed before the filtered level changes.

Ports:
iPlbClk  in  1  system clock.
iPlbResetN  in  1  asynchronous active-low reset.
iScl  in  1  bus SCL.
iSda  in  1  bus SDA.
oSda  out  1  SDA drive; 0=pull low, 1=release.
iEnable  in  1  0 = ignore bus, release SDA.
iRxAck  in  1  1 = ACK received write bytes, 0 = NACK.
oRxData  out  8  last byte written by master.
oRxValid  out  1  one-cycle strobe, oRxData new.
oRxFirst  out  1  qualifies oRxValid: first data byte after an address.
iTxData  in  8  next byte for master reads; held stable by local side.
oTxReq  out  1  one-cycle strobe: iTxData latched, present the next byte.
oNackRx  out  1  one-cycle strobe: master NACKed a read byte.
oStopSeen  out  1  one-cycle strobe: STOP ended an addressed transfer.
oBusy  out  1  between START and STOP, any address.
oAddrMatch  out  1  this target selected in the current transfer.

Behaviour:
- Reset (async, immediate): oSda=1, oRxData=0, all strobes 0, oBusy=0, oAddrMatch=0, state IDLE. Filtered lines reset to 1, so no edge is detected on release.
- Line path per input: SYNC_STAGES flops, then glitch filter, then rise/fall detect. Latency L = SYNC_STAGES+FILTER_LEN clocks. Each SCL high and low phase must last at least L+2 clocks.
- START = filtered SDA fall while filtered SCL high. STOP = filtered SDA rise while filtered SCL high.
- START or STOP wins over any SCL event in the same cycle. Both are honoured from every state.
- START (iEnable=1): go to ADDR, bitCnt=7, oBusy=1, oAddrMatch=0. A repeated START is handled identically.
- STOP: go to IDLE, oSda=1, oBusy=0. Pulse oStopSeen if oAddrMatch=1, then clear oAddrMatch.
- iEnable=0: next cycle go to IDLE, oSda=1, oBusy=0. START is ignored while disabled.
- Input bits are sampled on filtered SCL rise. oSda changes only on the cycle after a filtered SCL fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits. After the 8th rise, compare shift[7:1] with SLAVE_ADDR. On match: latch rw=bit0, set oAddrMatch=1, and at the next fall enter ADDR_ACK with oSda=0. On mismatch: enter IGNORE.
  - ADDR_ACK: hold oSda=0; exit on the next fall.
    - rw=1: latch iTxData into txShift, pulse oTxReq, set oSda=txShift[7], enter RD_DATA.
    - rw=0: set oSda=1, enter WR_DATA, arm oRxFirst.
  - WR_DATA: shift in 8 bits. One cycle after the 8th rise: oRxData=byte, oRxValid=1, oRxFirst=armed, then disarm. At the next fall sample iRxAck, set oSda=~iRxAck, enter WR_ACK.
  - WR_ACK: at the next fall, oSda=1 and return to WR_DATA.
  - RD_DATA: on each fall, shift out the next bit. On the fall that ends bit 0, oSda=1 and enter RD_ACK.
  - RD_ACK: sample SDA on the rise.
    - SDA=0 (master ACK): at the fall, reload iTxData, pulse oTxReq, drive the MSB, enter RD_DATA.
    - SDA=1 (master NACK): pulse oNackRx, enter IGNORE.
  - IGNORE: oSda=1 until START or STOP.
- Bus timing: more than 8 SCL cycles with no STOP keeps the current pattern; there is no timeout.
- If STOP or START arrives mid-byte, the partial byte is discarded with no strobe.

Decomposition:
- Shared package twi_pkg:
  - state enumeration (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE);
  - TWI_ACK=0 and TWI_NACK=1;
  - TWI_RW_READ=1.
- Sub-module twi_line_filter: synchronizer, glitch filter and rise/fall pulses. Instantiated once for SCL and once for SDA.

Test Plan:
- Write: START, 0xA0, 0x3C, STOP with iRxAck=1 → oSda=0 in both ACK slots. One oRxValid with oRxData=0x3C and oRxFirst=1. One oStopSeen; oBusy returns to 0.
- Read: START, 0xA1, iTxData=0x96 then 0x5A; master ACKs byte 1 and NACKs byte 2 → SDA bits 10010110 then 01011010. Two oTxReq pulses, one oNackRx, SDA released after byte 2.
- Mismatch: START, 0xA2, data, STOP → oSda stays 1 throughout. oAddrMatch=0, no strobes, oStopSeen=0, oBusy=1 during the transfer.
- Write 0xA0, 0x11, 0x22 with iRxAck dropped to 0 before byte 2 → ACK slot 1 has oSda=0, ACK slot 2 has oSda=1. Two oRxValid strobes; oRxFirst only on 0x11.
- Repeated START: 0xA0, 0x10, Sr, 0xA1, read 1 byte NACK, STOP → oRxFirst on 0x10, address re-ACKed after Sr, one oTxReq, one oStopSeen.
- Robustness:
  - assert iPlbResetN=0 mid read while oSda=0 → oSda=1 in the same cycle, asynchronously;
  - a 1-clock SCL glitch inside an ADDR bit causes no extra bit shift.
